axi4_lite_arbiter: RTL and testbench
====================================

// Module: axi4_lite_arbiter
// PURPOSE
//  Two-requester round-robin arbiter in front of the AXI4-Lite master's request interface.
//  - Port 0 is instruction fetch; port 1 is the load/store unit. Both share one master.
//  - Latches the winning request and holds address/data stable for the whole transaction.
//  - Issues exactly one read or write pulse to the master, waits for completion, returns data/resp.
// PARAMETERS
//  ADDR_WIDTH      32   address width
//  DATA_WIDTH      32   data width; strobe width is DATA_WIDTH/8
//  TIMEOUT_CYCLES  256  watchdog limit in WAIT, in cycles (used only with ARB_TIMEOUT_EN)
// PORTS
//  iCLK          in   1        clock; all logic on the rising edge
//  iRST          in   1        synchronous reset, active-low
//  pN_req        in   1        N=0,1: request; held high until pN_done
//  pN_we         in   1        1 = write, 0 = read
//  pN_addr       in   ADDR_W   address
//  pN_wdata      in   DATA_W   write data
//  pN_wstrb      in   DATA_W/8 write strobes
//  pN_rdata      out  DATA_W   read data; valid when pN_done=1
//  pN_resp       out  2        BRESP/RRESP; valid when pN_done=1
//  pN_done       out  1        one-cycle completion pulse
//  m_write_req   out  1        to master write_req
//  m_read_req    out  1        to master read_req
//  m_write_addr  out  ADDR_W   to master write_addr
//  m_write_data  out  DATA_W   to master write_data
//  m_write_strb  out  DATA_W/8 to master write_strb
//  m_read_addr   out  ADDR_W   to master read_addr
//  m_done        in   1        pulse on B or R handshake (BVALID&BREADY | RVALID&RREADY)
//  m_rdata       in   DATA_W   master read_data, sampled when m_done=1
//  m_resp        in   2        master write_resp/read_resp, sampled when m_done=1
//  grant         out  1        owner of the current or last transaction (0/1)
//  busy          out  1        high in any state other than IDLE
// BEHAVIOUR
//  - States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//  - IDLE
//    - Any pN_req high: pick a winner, latch its we/addr/wdata/wstrb, set grant, go to ISSUE.
//    - Both requests high: grant goes to the port that is not last_grant (round-robin).
//    - After reset, last_grant=1, so port 0 wins the first tie.
//  - ISSUE (1 cycle)
//    - m_write_req=we or m_read_req=!we, high for exactly this cycle; go to WAIT.
//  - WAIT
//    - Hold latched addr/data/strb stable on the m_* outputs.
//    - On m_done: capture m_rdata/m_resp, set last_grant=grant, go to RESP.
//  - RESP (1 cycle)
//    - p[grant]_done=1 with the captured rdata/resp; go to IDLE.
//    - The requester drops req on the cycle after done. The arbiter does not re-sample in RESP.
//  - Latency: request seen in IDLE at cycle t -> ISSUE at t+1 -> earliest done pulse at
//    t+3 + master latency.
//  - The non-granted port is ignored while busy; its req stays pending and is served next.
//  - m_done outside WAIT is ignored.
//  - Outputs are registered. The m_write_addr/m_read_addr/m_write_data/m_write_strb outputs
//    carry latched values in ISSUE and WAIT, and 0 otherwise.
//  - pN_rdata/pN_resp are 0 except in the pN_done cycle.
//  - Reset (also mid-transaction):
//    - state=IDLE, last_grant=1, grant=0, busy=0, all req/done=0, all data outputs=0.
//    - The master is reset from the same iRST, so no transaction is left dangling.
// CONFIGURATION
//  - ARB_TIMEOUT_EN defined:
//    - A counter is cleared on entry to WAIT and increments each cycle in WAIT.
//    - When it reaches TIMEOUT_CYCLES-1 without m_done: go to RESP with resp=2'b10 (SLVERR)
//      and rdata=0.
//    - m_done in the same cycle as the timeout wins (normal completion).
//    - The counter width is $clog2(TIMEOUT_CYCLES).
//  - ARB_TIMEOUT_EN undefined: no counter; WAIT lasts until m_done, indefinitely.
// TESTING
//  1. p0 read 0x1000; master returns m_rdata=0xDEADBEEF, m_resp=0 after 4 cycles
//     -> one m_read_req pulse, m_read_addr=0x1000 stable; p0_done pulse, p0_rdata=0xDEADBEEF.
//  2. p1 write 0x2004 data 0x55AA wstrb 0x3 -> one m_write_req pulse with those values;
//     p1_done with p1_resp=0; p0 outputs stay 0.
//  3. p0 and p1 both request from reset, repeated 4 times -> grant order 0,1,0,1;
//     each done only after its own m_done.
//  4. p1 requests while a p0 transaction is in WAIT -> p1 is served after p0_done;
//     no second m_*_req pulse during WAIT.
//  5. iRST low during WAIT -> next cycle state IDLE, busy=0, no done pulse;
//     after release, a pending p0 req is reissued.
//  6. ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, m_done never asserted
//     -> pN_done 16 cycles after WAIT entry, resp=2'b10, rdata=0.

Source files
------------

// File: rtl/axi4_lite_arbiter.sv
// axi4_lite_arbiter: two-port round-robin arbiter feeding one AXI4-Lite master request interface
// Purpose : port 0 (instruction fetch) and port 1 (load/store) share one master; the winning
//           request is latched, issued as a single read/write pulse, and its response is
//           returned as a one-cycle done pulse on the owning port.
// Option  : define ARB_TIMEOUT_EN to add a WAIT watchdog that answers SLVERR after
//           TIMEOUT_CYCLES cycles without m_done.
// Ports   : iCLK/iRST        clock, synchronous active-low reset
//           pN_req/we/addr/wdata/wstrb   requester N inputs (N=0,1)
//           pN_rdata/resp/done           requester N response, valid only in the done cycle
//           m_write_req/m_read_req       one-cycle request pulses to the master
//           m_write_addr/data/strb, m_read_addr  latched request, 0 outside ISSUE/WAIT
//           m_done/m_rdata/m_resp        master completion and response
//           grant/busy                   current or last owner, not-IDLE flag
module axi4_lite_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    iCLK,
    input  logic                    iRST,
    input  logic                    p0_req,
    input  logic                    p0_we,
    input  logic [ADDR_WIDTH-1:0]   p0_addr,
    input  logic [DATA_WIDTH-1:0]   p0_wdata,
    input  logic [DATA_WIDTH/8-1:0] p0_wstrb,
    output logic [DATA_WIDTH-1:0]   p0_rdata,
    output logic [1:0]              p0_resp,
    output logic                    p0_done,
    input  logic                    p1_req,
    input  logic                    p1_we,
    input  logic [ADDR_WIDTH-1:0]   p1_addr,
    input  logic [DATA_WIDTH-1:0]   p1_wdata,
    input  logic [DATA_WIDTH/8-1:0] p1_wstrb,
    output logic [DATA_WIDTH-1:0]   p1_rdata,
    output logic [1:0]              p1_resp,
    output logic                    p1_done,
    output logic                    m_write_req,
    output logic                    m_read_req,
    output logic [ADDR_WIDTH-1:0]   m_write_addr,
    output logic [DATA_WIDTH-1:0]   m_write_data,
    output logic [DATA_WIDTH/8-1:0] m_write_strb,
    output logic [ADDR_WIDTH-1:0]   m_read_addr,
    input  logic                    m_done,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_resp,
    output logic                    grant,
    output logic                    busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t                  r_state, w_next;
    logic                    r_last_grant, r_grant, r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata, r_rdata;
    logic [DATA_WIDTH/8-1:0] r_wstrb;
    logic [1:0]              r_resp;
    logic                    w_any, w_win, w_timeout, w_finish, w_act;
    assign w_any    = p0_req | p1_req;
    // On a tie the port that did not own the last completed transaction wins.
    assign w_win    = (p0_req & p1_req) ? ~r_last_grant : p1_req;
    assign w_finish = (r_state == WAIT) && (m_done || w_timeout);
    assign w_act    = (r_state == ISSUE) || (r_state == WAIT);
`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] r_cnt;
    // Held at zero outside WAIT, so it starts from zero on every WAIT entry.
    always_ff @(posedge iCLK) begin
        if (!iRST || r_state != WAIT) r_cnt <= '0;
        else                          r_cnt <= r_cnt + 1'b1;
    end
    // A real completion in the same cycle takes priority over the watchdog.
    assign w_timeout = (r_state == WAIT) && !m_done && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    assign w_timeout = 1'b0;
`endif
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_any ? ISSUE : IDLE;
            ISSUE:   w_next = WAIT;
            WAIT:    w_next = w_finish ? RESP : WAIT;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_rdata      <= '0;
            r_resp       <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_any) begin
                r_grant <= w_win;
                r_we    <= w_win ? p1_we    : p0_we;
                r_addr  <= w_win ? p1_addr  : p0_addr;
                r_wdata <= w_win ? p1_wdata : p0_wdata;
                r_wstrb <= w_win ? p1_wstrb : p0_wstrb;
            end
            if (w_finish) begin
                r_last_grant <= r_grant;
                r_rdata      <= m_done ? m_rdata : '0;
                r_resp       <= m_done ? m_resp  : 2'b10;
            end
        end
    end
    assign m_write_req  = (r_state == ISSUE) &&  r_we;
    assign m_read_req   = (r_state == ISSUE) && !r_we;
    assign m_write_addr = w_act ? r_addr  : '0;
    assign m_read_addr  = w_act ? r_addr  : '0;
    assign m_write_data = w_act ? r_wdata : '0;
    assign m_write_strb = w_act ? r_wstrb : '0;
    assign p0_done      = (r_state == RESP) && !r_grant;
    assign p1_done      = (r_state == RESP) &&  r_grant;
    assign p0_rdata     = p0_done ? r_rdata : '0;
    assign p0_resp      = p0_done ? r_resp  : '0;
    assign p1_rdata     = p1_done ? r_rdata : '0;
    assign p1_resp      = p1_done ? r_resp  : '0;
    assign grant        = r_grant;
    assign busy         = r_state != IDLE;
endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// tb_axi4_lite_arbiter: randomized transaction-level check of axi4_lite_arbiter against a round-robin model
module tb_axi4_lite_arbiter;
    logic        iCLK = 1'b0;
    logic        iRST;
    logic        req [2];
    logic        we [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [3:0]  wstrb [2];
    logic [31:0] p0_rdata, p1_rdata, m_write_addr, m_write_data, m_read_addr, m_rdata;
    logic [1:0]  p0_resp, p1_resp, m_resp;
    logic [3:0]  m_write_strb;
    logic        p0_done, p1_done, m_write_req, m_read_req, m_done, grant, busy;
    int          n_checks = 0;
    int          n_errors = 0;
    int          last = 1;
    always #5 iCLK = ~iCLK;
    axi4_lite_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .iCLK(iCLK), .iRST(iRST),
        .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]), .p0_wstrb(wstrb[0]),
        .p0_rdata(p0_rdata), .p0_resp(p0_resp), .p0_done(p0_done),
        .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]), .p1_wstrb(wstrb[1]),
        .p1_rdata(p1_rdata), .p1_resp(p1_resp), .p1_done(p1_done),
        .m_write_req(m_write_req), .m_read_req(m_read_req), .m_write_addr(m_write_addr),
        .m_write_data(m_write_data), .m_write_strb(m_write_strb), .m_read_addr(m_read_addr),
        .m_done(m_done), .m_rdata(m_rdata), .m_resp(m_resp), .grant(grant), .busy(busy)
    );
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask
    function automatic logic done_of(input int p);
        return p == 1 ? p1_done : p0_done;
    endfunction
    function automatic logic [31:0] rdata_of(input int p);
        return p == 1 ? p1_rdata : p0_rdata;
    endfunction
    function automatic logic [1:0] resp_of(input int p);
        return p == 1 ? p1_resp : p0_resp;
    endfunction
    task automatic load(input int p);
        we[p]    = 1'($urandom_range(0, 1));
        addr[p]  = $urandom;
        wdata[p] = $urandom;
        wstrb[p] = 4'($urandom_range(0, 15));
    endtask
    // Acts as the master for one transaction expected from port p, n_exp cycles after the call.
    task automatic serve(input int p, input int n_exp, input int lat, input logic [31:0] rd,
                         input logic [1:0] rs, input bit raise_other);
        int n = 0;
        int extra = 0;
        do begin
            tick();
            n++;
        end while (!(m_read_req || m_write_req) && n < 12);
        check("issue_lat", n, n_exp);
        check("grant", grant, p);
        check("busy_issue", busy, 1);
        check("write_pulse", m_write_req, we[p]);
        check("read_pulse", m_read_req, !we[p]);
        check("addr", we[p] ? m_write_addr : m_read_addr, addr[p]);
        check("wdata", m_write_data, wdata[p]);
        check("wstrb", m_write_strb, wstrb[p]);
        if ($urandom_range(0, 1) == 1) begin
            m_done  = 1'b1;
            m_rdata = $urandom;
            m_resp  = 2'b11;
        end
        tick();
        m_done = 1'b0;
        if (raise_other) req[1-p] = 1'b1;
        repeat (lat) begin
            extra += int'(m_read_req) + int'(m_write_req);
            tick();
        end
        extra += int'(m_read_req) + int'(m_write_req);
        check("single_pulse", extra, 0);
        check("addr_hold", m_read_addr, addr[p]);
        check("done_early", done_of(p), 0);
        m_done  = 1'b1;
        m_rdata = rd;
        m_resp  = rs;
        tick();
        m_done  = 1'b0;
        m_rdata = '0;
        m_resp  = '0;
        check("done", done_of(p), 1);
        check("rdata", rdata_of(p), rd);
        check("resp", resp_of(p), rs);
        check("other_done", done_of(1 - p), 0);
        check("other_rdata", rdata_of(1 - p), 0);
        check("addr_resp_zero", m_write_addr, 0);
        req[p] = 1'b0;
    endtask
    task automatic round(input int kind);
        int first;
        load(0);
        load(1);
        case (kind)
            0: begin
                req[0] = 1'b1;
                serve(0, 1, $urandom_range(0, 4), $urandom, 2'($urandom_range(0, 3)), 1'b0);
                last = 0;
            end
            1: begin
                req[1] = 1'b1;
                serve(1, 1, $urandom_range(0, 4), $urandom, 2'($urandom_range(0, 3)), 1'b0);
                last = 1;
            end
            2: begin
                req[0] = 1'b1;
                req[1] = 1'b1;
                first = last == 1 ? 0 : 1;
                serve(first, 1, $urandom_range(0, 4), $urandom, 2'($urandom_range(0, 3)), 1'b0);
                serve(1 - first, 2, $urandom_range(0, 4), $urandom, 2'($urandom_range(0, 3)), 1'b0);
                last = 1 - first;
            end
            default: begin
                req[0] = 1'b1;
                serve(0, 1, $urandom_range(0, 4), $urandom, 2'($urandom_range(0, 3)), 1'b1);
                serve(1, 2, $urandom_range(0, 4), $urandom, 2'($urandom_range(0, 3)), 1'b0);
                last = 1;
            end
        endcase
        tick();
        check("idle_busy", busy, 0);
        check("grant_hold", grant, last);
    endtask
    initial begin
        int n;
        iRST    = 1'b0;
        m_done  = 1'b0;
        m_rdata = '0;
        m_resp  = '0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b0;
            we[i] = 1'b0;
            addr[i] = '0;
            wdata[i] = '0;
            wstrb[i] = '0;
        end
        repeat (2) tick();
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 0);
        check("rst_req", {m_write_req, m_read_req, p0_done, p1_done}, 0);
        check("rst_data", {m_write_addr, m_read_addr}, 0);
        iRST = 1'b1;
        we[0] = 1'b0; addr[0] = 32'h1000; wdata[0] = '0; wstrb[0] = '0; req[0] = 1'b1;
        serve(0, 1, 4, 32'hDEADBEEF, 2'b00, 1'b0);
        last = 0;
        tick();
        check("t1_idle", busy, 0);
        we[1] = 1'b1; addr[1] = 32'h2004; wdata[1] = 32'h55AA; wstrb[1] = 4'h3; req[1] = 1'b1;
        serve(1, 1, 2, 32'h0, 2'b00, 1'b0);
        last = 1;
        tick();
        check("t2_idle", busy, 0);
        repeat (4) round(2);
        round(3);
        load(0);
        req[0] = 1'b1;
        tick();
        tick();
        check("pre_rst_busy", busy, 1);
        iRST = 1'b0;
        tick();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", {p0_done, p1_done}, 0);
        check("mid_rst_grant", grant, 0);
        check("mid_rst_addr", m_read_addr, 0);
        iRST = 1'b1;
        last = 1;
        serve(0, 1, 1, $urandom, 2'b00, 1'b0);
        last = 0;
        tick();
        for (int r = 0; r < 40; r++) round($urandom_range(0, 3));
`ifdef ARB_TIMEOUT_EN
        load(0);
        we[0] = 1'b0;
        req[0] = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!m_read_req && n < 5);
        n = 0;
        do begin
            tick();
            n++;
        end while (!p0_done && n < 40);
        check("timeout_lat", n, 17);
        check("timeout_resp", p0_resp, 2'b10);
        check("timeout_rdata", p0_rdata, 0);
        req[0] = 1'b0;
        tick();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
